// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA widths and requester index constants
package dma_pkg;
  localparam int DMA_AW = 22;
  localparam int DMA_DW = 8;
  localparam int DMA_REQ_SD = 0;
  localparam int DMA_REQ_ZX = 1;
endpackage

// File: rtl/dma_tag_fifo.sv
// dma_tag_fifo: synchronous FIFO of requester tags for outstanding DMA accesses
// ports: push/wd write a tag, pop drops the head, rd is the head, empty/full status
module dma_tag_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wd,
  output logic [W-1:0] rd,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign rd = mem[rp[PW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= wd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: round-robin sharing of one DMA sequencer port among N requesters
// ports: req/addr/wd/rnw in and ack/done/rd out per requester;
// mem_req/mem_addr/mem_wd/mem_rnw out and mem_ack/mem_end/mem_rd in to the sequencer; err sticky
module dma_rr_arbiter import dma_pkg::*; #(
  parameter int N = 4,
  parameter int AW = DMA_AW,
  parameter int DW = DMA_DW,
  parameter int BURST_MAX = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wd,
  input  logic [N-1:0]  rnw,
  output logic [N-1:0]  ack,
  output logic [N-1:0]  done,
  output logic [DW-1:0] rd,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_rnw,
  input  logic          mem_ack,
  input  logic          mem_end,
  input  logic [DW-1:0] mem_rd,
  output logic          err
);
  localparam int OW = $clog2(N);
  logic [OW-1:0] owner, head, sel;
  logic own_vld, empty, full, acc, push, pop, rearb;
  logic [7:0] bcnt;
  logic [OW:0] win;
  // returns {found, index}; scans owner+1 .. owner so the current owner has lowest priority
  function automatic logic [OW:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] o);
    logic [OW:0] p;
    int j;
    p = '0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(o) + k) % N;
      if (r[j]) p = {1'b1, OW'(j)};
    end
    return p;
  endfunction
  assign sel = own_vld ? owner : '0;
  assign mem_addr = addr[int'(sel)*AW +: AW];
  assign mem_wd = wd[int'(sel)*DW +: DW];
  assign mem_rnw = rnw[sel];
  assign rd = mem_rd;
  assign mem_req = own_vld && req[owner] && !full;
  assign acc = mem_ack && mem_req;
  // an end arriving with the ack on an empty FIFO belongs to that ack and is never stored
  assign push = acc && !(empty && mem_end);
  assign pop = mem_end && !empty;
  assign rearb = !own_vld || !req[owner] || (acc && bcnt == 8'(BURST_MAX - 1));
  assign win = rr_pick(req, owner);
  always_comb begin
    ack = '0;
    done = '0;
    for (int i = 0; i < N; i++) begin
      ack[i] = acc && owner == OW'(i);
      done[i] = mem_end && (empty ? acc && owner == OW'(i) : head == OW'(i));
    end
  end
  dma_tag_fifo #(.W(OW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .wd(owner),
    .rd(head),
    .empty(empty),
    .full(full)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner <= OW'(N - 1);
      own_vld <= 1'b0;
      bcnt <= '0;
      err <= 1'b0;
    end else begin
      if ((mem_ack && !mem_req) || (mem_end && empty && !acc)) err <= 1'b1;
      if (rearb) begin
        own_vld <= win[OW];
        if (win[OW]) begin
          owner <= win[OW-1:0];
          bcnt <= '0;
        end
      end else if (acc) bcnt <= bcnt + 8'd1;
    end
endmodule
